mem_access_unit: RTL and testbench

- MEM-stage front end placed between the EX/MEM pipeline register and the word-addressed data memory.
- Accepts byte, halfword and word loads and stores from the pipeline.
- Holds stores in a small posted write buffer and drains them to memory one per cycle, using read-modify-write with a byte mask.
- Returns sign- or zero-extended load data one cycle after acceptance and back-pressures the pipeline when it cannot accept a request.

---
 rtl/mem_pkg.sv | 52 +++++
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_wbuf.sv | 91 +++++++++
 rtl/mem_access_unit.sv | 103 ++++++++++
 tb/tb_mem_access_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage access unit: size codes,
// write-buffer entry layout, byte-mask / lane / load-extend functions.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // idx holds the word index zero-extended to the full 30-bit word address
   typedef struct packed {
      logic [29:0] idx;
      logic [3:0]  mask;
      logic [31:0] data;
   } wbuf_ent_t;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         SZ_WORD: return off != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 4'b0001 << off;
         SZ_HALF: return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         SZ_BYTE: return {4{wdata[7:0]}};
         SZ_HALF: return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic uns, input logic [1:0] off);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (size)
         SZ_BYTE: return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         SZ_HALF: return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: return sh;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data-memory port bundle for mem_access_unit.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        load_valid;
   logic [31:0] load_data;
   logic        addr_error;
   logic        buf_empty;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
      output req_ready, load_valid, load_data, addr_error, buf_empty,
             mem_write, mem_address, mem_write_data
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
      input  req_ready, load_valid, load_data, addr_error, buf_empty,
             mem_write, mem_address, mem_write_data
   );
endinterface

// File: rtl/mem_wbuf.sv
// DEPTH-entry posted store FIFO with word-index match against a load address.
// Optional WBUF_FWD_EN adds youngest-entry forwarding of fully covered loads.
module mem_wbuf
   import mem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push_i,
   input  wbuf_ent_t   push_ent_i,
   input  logic        pop_i,
   output wbuf_ent_t   head_o,
   output logic        full_o,
   output logic        empty_o,
   input  logic [29:0] match_idx_i,
   input  logic [3:0]  match_mask_i,
   output logic        hit_o,
   output logic        fwd_ok_o,
   output logic [31:0] fwd_data_o
);
   localparam int PW  = $clog2(DEPTH);
   localparam int PW1 = PW + 1;

   wbuf_ent_t        ent_q [DEPTH];
   logic [PW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ;
   logic             empty_q;
   logic [PW-1:0]    slot [DEPTH];
   logic [DEPTH-1:0] match_age;

   assign wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push_i};
   assign rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop_i};

   always_ff @(posedge clk) begin
      if (push_i) ent_q[wr_ptr_q[PW-1:0]] <= push_ent_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         empty_q  <= (wr_ptr_d == rd_ptr_d);
      end
   end

   assign head_o  = ent_q[rd_ptr_q[PW-1:0]];
   assign empty_o = empty_q;
   assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

   // match_age bit 0 is the oldest (head) entry
   always_comb begin
      occ = wr_ptr_q - rd_ptr_q;
      for (int k = 0; k < DEPTH; k++) begin
         slot[k]      = rd_ptr_q[PW-1:0] + PW'(k);
         match_age[k] = (PW1'(k) < occ) && (ent_q[slot[k]].idx == match_idx_i);
      end
   end

   assign hit_o = |match_age;

`ifdef WBUF_FWD_EN
   logic [3:0] yng_mask;
   logic       conflict;

   always_comb begin
      yng_mask   = '0;
      fwd_data_o = '0;
      conflict   = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (match_age[k]) begin
            yng_mask   = ent_q[slot[k]].mask;
            fwd_data_o = ent_q[slot[k]].data;
         end
      end
      for (int k = 0; k < DEPTH; k++) begin
         if (match_age[k] && |(ent_q[slot[k]].mask & ~yng_mask)) conflict = 1'b1;
      end
      fwd_ok_o = hit_o && ((yng_mask & match_mask_i) == match_mask_i) && !conflict;
   end
`else
   logic fwd_unused;
   assign fwd_unused = ^match_mask_i;
   assign fwd_ok_o   = 1'b0;
   assign fwd_data_o = '0;
`endif

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage front end: load/store acceptance, memory-port arbitration with
// read-modify-write drain, and load formatting. WBUF_FWD_EN enables forwarding.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int WORD_BITS = 10
) (
   input  logic              clk,
   input  logic              reset,
   mem_access_unit_if.slave  bus
);
   logic        misalign, stall, full, empty, hit, fwd_ok, pop;
   logic        req_acc, is_load, ld_acc, st_acc;
   logic [31:0] fwd_data, src_word, head_bits;
   wbuf_ent_t   new_ent, head;

   logic        load_valid_q, load_valid_d;
   logic        addr_error_q, addr_error_d;
   logic [31:0] load_data_q, load_data_d;

   assign misalign     = misaligned(bus.req_size, bus.req_addr[1:0]);
   assign new_ent.idx  = 30'(bus.req_addr[WORD_BITS+1:2]);
   assign new_ent.mask = byte_mask(bus.req_size, bus.req_addr[1:0]);
   assign new_ent.data = lane_data(bus.req_size, bus.req_wdata);

`ifdef WBUF_FWD_EN
   assign stall    = hit & ~fwd_ok;
   assign src_word = fwd_ok ? fwd_data : bus.mem_read_data;
`else
   logic fwd_unused;
   assign fwd_unused = fwd_ok ^ (^fwd_data);
   assign stall      = hit;
   assign src_word   = bus.mem_read_data;
`endif

   // Ready depends only on registered buffer state, never on this cycle's drain
   assign bus.req_ready = bus.req_write ? ~full : (misalign | ~stall);
   assign req_acc       = bus.req_valid & bus.req_ready;
   assign is_load       = req_acc & ~bus.req_write;
   assign ld_acc        = is_load & ~misalign;
   assign st_acc        = req_acc & bus.req_write & ~misalign;
   assign pop           = ~empty & ~ld_acc;

   mem_wbuf #(.DEPTH(DEPTH)) u_wbuf (
      .clk          (clk),
      .rst_n        (reset),
      .push_i       (st_acc),
      .push_ent_i   (new_ent),
      .pop_i        (pop),
      .head_o       (head),
      .full_o       (full),
      .empty_o      (empty),
      .match_idx_i  (new_ent.idx),
      .match_mask_i (new_ent.mask),
      .hit_o        (hit),
      .fwd_ok_o     (fwd_ok),
      .fwd_data_o   (fwd_data)
   );

   assign head_bits = {{8{head.mask[3]}}, {8{head.mask[2]}}, {8{head.mask[1]}}, {8{head.mask[0]}}};

   always_comb begin
      bus.mem_write      = 1'b0;
      bus.mem_address    = '0;
      bus.mem_write_data = '0;
      if (ld_acc) begin
         bus.mem_address = {bus.req_addr[31:2], 2'b00};
      end else if (pop) begin
         bus.mem_write      = 1'b1;
         bus.mem_address    = {head.idx, 2'b00};
         bus.mem_write_data = (bus.mem_read_data & ~head_bits) | (head.data & head_bits);
      end
   end

   always_comb begin
      load_valid_d = is_load;
      addr_error_d = req_acc & misalign;
      load_data_d  = load_data_q;
      if (is_load) begin
         load_data_d = misalign ? '0
                     : load_extend(src_word, bus.req_size, bus.req_unsigned, bus.req_addr[1:0]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_valid_q <= 1'b0;
         addr_error_q <= 1'b0;
         load_data_q  <= '0;
      end else begin
         load_valid_q <= load_valid_d;
         addr_error_q <= addr_error_d;
         load_data_q  <= load_data_d;
      end
   end

   assign bus.load_valid = load_valid_q;
   assign bus.addr_error = addr_error_q;
   assign bus.load_data  = load_data_q;
   assign bus.buf_empty  = empty;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random traffic checked
// against a byte-level memory model with a queue of pending stores.
module tb_mem_access_unit;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_access_unit_if bus();

   mem_access_unit #(.DEPTH(DEPTH), .WORD_BITS(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   bit [31:0]   dmem [1024];
   logic        pre_we;
   logic [9:0]  pre_idx;
   logic [31:0] pre_val;

   assign bus.mem_read_data = dmem[bus.mem_address[11:2]];

   always @(posedge clk) begin
      if (pre_we) dmem[pre_idx] <= pre_val;
      else if (bus.mem_write) dmem[bus.mem_address[11:2]] <= bus.mem_write_data;
   end

   typedef struct {
      logic [31:0] a;
      logic [1:0]  sz;
      logic [31:0] d;
   } st_t;

   st_t         q[$];
   byte unsigned rb [4096];
   int          ntot = 0;
   int          npass = 0;
   int          nfail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int nb(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit bad(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || ((a % nb(sz)) != 0);
   endfunction

   // Little-endian read of the model bytes, extended by plain arithmetic
   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
      logic [31:0] v;
      int n;
      v = 0;
      n = nb(sz);
      for (int k = 0; k < n; k++) v = v | (32'(rb[int'((a + k) % 4096)]) << (8 * k));
      if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic poke(input logic [31:0] a, input logic [31:0] val);
      pre_idx = a[11:2];
      pre_val = val;
      pre_we  = 1'b1;
      @(posedge clk);
      #1;
      pre_we  = 1'b0;
      for (int k = 0; k < 4; k++) rb[int'(a[11:2]) * 4 + k] = val[8*k +: 8];
   endtask

   // One request cycle; entered and left at posedge+1
   task automatic step(input logic v, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, output bit acc);
      bit rdy, ldacc, e_lv, e_ae;
      logic [31:0] e_ld;
      st_t h;
      bus.req_valid    = v;
      bus.req_write    = w;
      bus.req_size     = sz;
      bus.req_unsigned = u;
      bus.req_addr     = a;
      bus.req_wdata    = d;
      e_ld = 0;
      @(negedge clk);
      if (w) rdy = (q.size() < DEPTH);
      else if (bad(sz, a)) rdy = 1;
      else begin
         rdy = 1;
         foreach (q[i]) if (q[i].a[11:2] == a[11:2]) rdy = 0;
      end
      acc   = v && rdy;
      ldacc = acc && !w && !bad(sz, a);
      if (v) check("req_ready", 32'(bus.req_ready), 32'(rdy));
      if (ldacc) begin
         check("ld_addr", bus.mem_address, {a[31:2], 2'b00});
         check("ld_nowrite", 32'(bus.mem_write), 0);
         e_ld = model_load(sz, u, a);
      end else if (q.size() > 0) begin
         h = q.pop_front();
         for (int k = 0; k < nb(h.sz); k++) rb[int'((h.a + k) % 4096)] = h.d[8*k +: 8];
         check("drain_we", 32'(bus.mem_write), 1);
         check("drain_addr", bus.mem_address, {h.a[31:2], 2'b00});
         check("drain_data", bus.mem_write_data, model_load(2'd2, 1'b1, {h.a[31:2], 2'b00}));
      end else begin
         check("idle_we", 32'(bus.mem_write), 0);
      end
      if (acc && w && !bad(sz, a)) q.push_back('{a, sz, d});
      e_lv = acc && !w;
      e_ae = acc && bad(sz, a);
      @(posedge clk);
      #1;
      check("load_valid", 32'(bus.load_valid), 32'(e_lv));
      check("addr_error", 32'(bus.addr_error), 32'(e_ae));
      if (e_lv) check("load_data", bus.load_data, e_ld);
      check("buf_empty", 32'(bus.buf_empty), 32'(q.size() == 0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      bit acc;
      int n;
      logic [1:0] sz;
      logic [31:0] a;

      bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_unsigned = 0;
      bus.req_addr = 0; bus.req_wdata = 0;
      pre_we = 0; pre_idx = 0; pre_val = 0;
      reset = 0;

      poke(32'h200, 32'h1122_3344);
      poke(32'h100, 32'h8001_0000);
      check("rst_load_valid", 32'(bus.load_valid), 0);
      check("rst_load_data", bus.load_data, 0);
      check("rst_addr_error", 32'(bus.addr_error), 0);
      check("rst_buf_empty", 32'(bus.buf_empty), 1);
      check("rst_mem_write", 32'(bus.mem_write), 0);
      check("rst_mem_address", bus.mem_address, 0);
      @(negedge clk) reset = 1;
      @(posedge clk);
      #1;

      // byte store merged into an existing word
      step(1, 1, 2'd0, 0, 32'h201, 32'h0000_00AB, acc);
      step(0, 0, 2'd0, 0, 32'h0, 32'h0, acc);
      check("sb_merge", dmem[128], 32'h1122_AB44);

      step(1, 0, 2'd1, 0, 32'h102, 32'h0, acc);
      check("lh_signed", bus.load_data, 32'hFFFF_8001);
      step(1, 0, 2'd1, 1, 32'h102, 32'h0, acc);
      check("lhu", bus.load_data, 32'h0000_8001);

      // load behind a matching buffered store
      step(1, 1, 2'd2, 0, 32'h40, 32'hDEAD_BEEF, acc);
      n = 0;
      do begin
         step(1, 0, 2'd2, 0, 32'h40, 32'h0, acc);
         n++;
      end while (!acc && n < 8);
      check("lw_stall_cycles", n, 2);
      check("lw_after_sw", bus.load_data, 32'hDEAD_BEEF);

      step(1, 0, 2'd2, 0, 32'h42, 32'h0, acc);
      check("mis_lw_err", 32'(bus.addr_error), 1);
      check("mis_lw_valid", 32'(bus.load_valid), 1);
      check("mis_lw_data", bus.load_data, 0);
      step(1, 1, 2'd1, 0, 32'h43, 32'h5555, acc);
      check("mis_sh_err", 32'(bus.addr_error), 1);
      check("mis_sh_empty", 32'(bus.buf_empty), 1);
      step(0, 0, 2'd0, 0, 32'h0, 32'h0, acc);
      check("mis_mem_kept", dmem[16], 32'hDEAD_BEEF);

      // reset while a store is draining discards it
      step(1, 1, 2'd2, 0, 32'h80, 32'h1234_5678, acc);
      bus.req_valid = 0;
      #1;
      check("drain_live", 32'(bus.mem_write), 1);
      #2 reset = 0;
      #1;
      check("rst_mid_we", 32'(bus.mem_write), 0);
      check("rst_mid_empty", 32'(bus.buf_empty), 1);
      check("rst_mid_addr", bus.mem_address, 0);
      q.delete();
      @(negedge clk) reset = 1;
      @(posedge clk);
      #1;
      check("rst_mid_mem", dmem[32], 32'h0);

      for (int i = 0; i < 400; i++) begin
         sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a  = 32'($urandom_range(0, 255));
         if ($urandom % 4 != 0 && sz != 2'd3) a = a - (a % nb(sz));
         step(($urandom % 4) != 0, $urandom % 2, sz, $urandom % 2, a, $urandom, acc);
      end
      for (int i = 0; i < 6; i++) step(0, 0, 2'd0, 0, 32'h0, 32'h0, acc);
      for (int i = 0; i < 128; i++) check("final_mem", dmem[i], model_load(2'd2, 1'b1, 32'(i * 4)));

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
